// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: per-column sequencer that paces activation bytes into one PE,
// generating its step index, weight-load pulse, finish and end-of-row strobes.
// Latency: busy is visible the cycle after start; pe_weight_load in the first
// busy cycle; each pixel takes N STEP cycles (N=3 for mode E, else 2) plus one
// FIN cycle; done pulses in the cycle after the last finish.
// Backpressure: act_valid low stalls STEP in place. A finish that would write
// the PE output FIFO (tt mirror set) waits in HOLD while fifo_full is high and
// issues combinationally in the first cycle fifo_full is low.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start, cfg_mode, cfg_row_len, cfg_num_rows    pass request and config
//   act_valid / act_ready        activation buffer handshake
//   fifo_full                    PE output FIFO full flag
//   pe_state, pe_weight_mode, pe_weight_load, pe_finish, pe_end_of_row  PE control
//   busy, done                   scheduler status
//   perf_stall_cnt               stall counter, present only when the
//                                PE_SEQ_CTRL_PERF_EN macro is defined (else 0)

module pe_seq_ctrl #(
  parameter int COL_W  = 8,
  parameter int ROW_W  = 8,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cfg_mode,
  input  logic [COL_W-1:0]  cfg_row_len,
  input  logic [ROW_W-1:0]  cfg_num_rows,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic              fifo_full,
  output logic [1:0]        pe_state,
  output logic [2:0]        pe_weight_mode,
  output logic              pe_weight_load,
  output logic              pe_finish,
  output logic              pe_end_of_row,
  output logic              busy,
  output logic              done,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_STEP  = 3'd2,
    S_FIN   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0]       MODE_E  = 3'd0;
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  state_t            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  row_len_q, row_len_d;
  logic [ROW_W-1:0]  num_rows_q, num_rows_d;
  logic [2:0]        mode_q, mode_d;
  logic              tt_q, tt_d;
  logic              busy_q, busy_d;

  logic [1:0]        n_steps;
  logic              at_eor;
  logic              last_row;
  logic              write_pending;
  logic              start_acc;

  // Mode E is the only three-step mode; codes 5-7 fall in with A (two steps).
  assign n_steps       = (mode_q == MODE_E) ? 2'd3 : 2'd2;
  assign at_eor        = (col_q == row_len_q - COL_ONE);
  assign last_row      = (row_q == num_rows_q - ROW_ONE);
  // The PE writes its output FIFO only on finishes where its tick/tock is set.
  assign write_pending = tt_q & fifo_full;
  assign start_acc     = (state_q == S_IDLE) & start;

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    col_d         = col_q;
    row_d         = row_q;
    row_len_d     = row_len_q;
    num_rows_d    = num_rows_q;
    mode_d        = mode_q;
    tt_d          = tt_q;
    busy_d        = busy_q;
    act_ready     = 1'b0;
    pe_state      = 2'd0;
    pe_finish     = 1'b0;
    pe_end_of_row = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = cfg_mode;
          row_len_d  = cfg_row_len;
          num_rows_d = cfg_num_rows;
          tt_d       = (cfg_mode == MODE_E);
          col_d      = '0;
          row_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_WLOAD;
        end
      end

      S_WLOAD: begin
        step_d  = 2'd1;
        state_d = S_STEP;
      end

      S_STEP: begin
        act_ready = 1'b1;
        if (act_valid) begin
          pe_state = step_q;
          if (step_q == n_steps) begin
            state_d = S_FIN;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end

      // FIN and HOLD share the finish decision; HOLD simply re-evaluates it
      // every cycle so the finish goes out in the cycle fifo_full drops.
      S_FIN, S_HOLD: begin
        if (write_pending) begin
          state_d = S_HOLD;
        end else begin
          pe_finish     = 1'b1;
          pe_end_of_row = at_eor;
          step_d        = 2'd1;
          if (at_eor) begin
            tt_d    = 1'b0;
            col_d   = '0;
            row_d   = row_q + ROW_ONE;
            state_d = last_row ? S_DONE : S_STEP;
          end else begin
            tt_d    = ~tt_q;
            col_d   = col_q + COL_ONE;
            state_d = S_STEP;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= 2'd0;
      col_q      <= '0;
      row_q      <= '0;
      row_len_q  <= '0;
      num_rows_q <= '0;
      mode_q     <= 3'd0;
      tt_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      mode_q     <= mode_d;
      tt_q       <= tt_d;
      busy_q     <= busy_d;
    end
  end

  assign pe_weight_mode = mode_q;
  assign pe_weight_load = (state_q == S_WLOAD);
  assign done           = (state_q == S_DONE);
  assign busy           = busy_q;

`ifdef PE_SEQ_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              stall_cyc;

  assign stall_cyc = (state_q == S_HOLD) | ((state_q == S_STEP) & ~act_valid);

  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if (stall_cyc && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  // start_acc only feeds the stall counter; keep it referenced.
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign perf_stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: self-checking bench for pe_seq_ctrl.
// Expected step indices and end-of-row flags are queued per pass from a
// reference walk of the pass and popped as the DUT emits pe_state / pe_finish.

module tb_pe_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  cfg_mode;
  logic [7:0]  cfg_row_len;
  logic [7:0]  cfg_num_rows;
  logic        act_valid;
  logic        act_ready;
  logic        fifo_full;
  logic [1:0]  pe_state;
  logic [2:0]  pe_weight_mode;
  logic        pe_weight_load;
  logic        pe_finish;
  logic        pe_end_of_row;
  logic        busy;
  logic        done;
  logic [31:0] perf_stall_cnt;

  pe_seq_ctrl #(.COL_W(8), .ROW_W(8), .PERF_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_mode       (cfg_mode),
    .cfg_row_len    (cfg_row_len),
    .cfg_num_rows   (cfg_num_rows),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .fifo_full      (fifo_full),
    .pe_state       (pe_state),
    .pe_weight_mode (pe_weight_mode),
    .pe_weight_load (pe_weight_load),
    .pe_finish      (pe_finish),
    .pe_end_of_row  (pe_end_of_row),
    .busy           (busy),
    .done           (done),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [1:0] exp_step_q[$];
  logic       exp_eor_q[$];
  int         fin_cyc[$];
  int         done_cyc;
  int         hs_cnt;
  int         rdy_in_ff;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic bit_at(input logic [63:0] m, input int c, input logic dflt);
    if (c < 64) return m[c];
    return dflt;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_rdy"}, 32'(act_ready), 0);
    check_eq({tag, "_state"}, 32'(pe_state), 0);
    check_eq({tag, "_wload"}, 32'(pe_weight_load), 0);
    check_eq({tag, "_fin"}, 32'(pe_finish), 0);
    check_eq({tag, "_eor"}, 32'(pe_end_of_row), 0);
    check_eq({tag, "_wmode"}, 32'(pe_weight_mode), 0);
    check_eq({tag, "_perf"}, perf_stall_cnt, 0);
  endtask

  // One pass: cycle 0 drives start with the IDLE controller. stray_at injects
  // a start with a different mode while busy; rst_at aborts with reset.
  task automatic run_pass(input logic [2:0] mode, input int rl, input int nr,
                          input logic [63:0] av_mask, input logic [63:0] ff_mask,
                          input int stray_at, input int rst_at);
    int n;
    int wl_cnt;
    int wl_cyc;
    bit got_done;
    n = (mode == 3'd0) ? 3 : 2;
    exp_step_q.delete();
    exp_eor_q.delete();
    fin_cyc.delete();
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < rl; c++) begin
        for (int s = 1; s <= n; s++) exp_step_q.push_back(2'(s));
        exp_eor_q.push_back(c == rl - 1);
      end
    end
    hs_cnt = 0; wl_cnt = 0; wl_cyc = -1; done_cyc = -1; got_done = 0; rdy_in_ff = 0;

    for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
      @(posedge clk); #1;
      if (cyc == rst_at) begin
        start = 0; act_valid = 0; fifo_full = 0;
        rst = 1;
        #1;
        check_reset_outputs("midrst");
        check_eq("midrst_wl_cnt", 32'(wl_cnt), 1);
        @(posedge clk); #1;
        rst = 0;
        exp_step_q.delete();
        exp_eor_q.delete();
        return;
      end
      start        = (cyc == 0) || (cyc == stray_at);
      cfg_mode     = (cyc == stray_at) ? 3'd3 : mode;
      cfg_row_len  = 8'(rl);
      cfg_num_rows = 8'(nr);
      act_valid    = bit_at(av_mask, cyc, 1'b1);
      fifo_full    = bit_at(ff_mask, cyc, 1'b0);
      @(negedge clk);
      check_eq("busy", 32'(busy), (cyc >= 1) ? 1 : 0);
      if (cyc >= 1) check_eq("wmode", 32'(pe_weight_mode), 32'(mode));
      if (!act_valid) check_eq("state_no_valid", 32'(pe_state), 0);
      if (!pe_finish) check_eq("eor_unqual", 32'(pe_end_of_row), 0);
      if (act_ready && fifo_full) rdy_in_ff++;
      if (act_valid && act_ready) hs_cnt++;
      if (pe_weight_load) begin
        wl_cnt++;
        wl_cyc = cyc;
      end
      if (pe_state != 2'd0) begin
        if (exp_step_q.size() == 0) check_eq("step_extra", 32'(pe_state), 0);
        else check_eq("step", 32'(pe_state), 32'(exp_step_q.pop_front()));
      end
      if (pe_finish) begin
        fin_cyc.push_back(cyc);
        if (exp_eor_q.size() == 0) check_eq("fin_extra", 1, 0);
        else check_eq("eor", 32'(pe_end_of_row), 32'(exp_eor_q.pop_front()));
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
    end

    check_eq("done_seen", 32'(got_done), 1);
    check_eq("wl_cnt", 32'(wl_cnt), 1);
    check_eq("wl_cyc", 32'(wl_cyc), 1);
    check_eq("hs_cnt", 32'(hs_cnt), 32'(n * rl * nr));
    check_eq("steps_left", 32'(exp_step_q.size()), 0);
    check_eq("eor_left", 32'(exp_eor_q.size()), 0);
    if (fin_cyc.size() > 0) check_eq("done_after_fin", 32'(done_cyc), 32'(fin_cyc[fin_cyc.size()-1] + 1));
    @(posedge clk); #1;
    start = 0; act_valid = 0; fifo_full = 0;
    @(negedge clk);
    check_eq("busy_after", 32'(busy), 0);
    check_eq("done_pulse", 32'(done), 0);
  endtask

  initial begin
    logic [63:0] m;
    logic [63:0] ones;
    int exp_perf;
    ones = '1;
    rst = 1; start = 0; cfg_mode = 0; cfg_row_len = 0; cfg_num_rows = 0;
    act_valid = 0; fifo_full = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 0;
    @(negedge clk);

    // Mode A, one row of two pixels.
    run_pass(3'd1, 2, 1, ones, 64'd0, -1, -1);
    check_eq("a_fin_cnt", 32'(fin_cyc.size()), 2);
    if (fin_cyc.size() == 2) begin
      check_eq("a_fin0", 32'(fin_cyc[0]), 4);
      check_eq("a_fin1", 32'(fin_cyc[1]), 7);
    end

    // Mode E, row_len 1: tt=1 blocks the first finish while full, then tt=0
    // lets the second finish through even though the FIFO is full.
    m = '0; m[5] = 1; m[6] = 1; m[11] = 1;
    run_pass(3'd0, 1, 2, ones, m, -1, -1);
    check_eq("e_fin_cnt", 32'(fin_cyc.size()), 2);
    if (fin_cyc.size() == 2) begin
      check_eq("e_fin0", 32'(fin_cyc[0]), 7);
      check_eq("e_fin1", 32'(fin_cyc[1]), 11);
    end
    check_eq("e_rdy_in_hold", 32'(rdy_in_ff), 0);

    // Mode B, full for 5 cycles at the second (tt=1) finish.
    m = '0; for (int i = 7; i <= 11; i++) m[i] = 1;
    run_pass(3'd2, 3, 1, ones, m, -1, -1);
    check_eq("b_fin_cnt", 32'(fin_cyc.size()), 3);
    if (fin_cyc.size() == 3) begin
      check_eq("b_fin1", 32'(fin_cyc[1]), 12);
      check_eq("b_fin2", 32'(fin_cyc[2]), 15);
    end
    check_eq("b_rdy_in_hold", 32'(rdy_in_ff), 0);
`ifdef PE_SEQ_CTRL_PERF_EN
    exp_perf = 5;
`else
    exp_perf = 0;
`endif
    check_eq("b_perf", perf_stall_cnt, 32'(exp_perf));

    // Mode C, act_valid 1,0,0,1 over the STEP cycles.
    m = ones; m[3] = 0; m[4] = 0;
    run_pass(3'd3, 1, 1, m, 64'd0, -1, -1);
`ifdef PE_SEQ_CTRL_PERF_EN
    exp_perf = 2;
`else
    exp_perf = 0;
`endif
    check_eq("c_perf", perf_stall_cnt, 32'(exp_perf));

    // Mode code 6 runs as A and is passed through unchanged.
    run_pass(3'd6, 2, 2, ones, 64'd0, -1, -1);
    check_eq("m6_fin_cnt", 32'(fin_cyc.size()), 4);

    // Stray start while busy, then reset mid-STEP, then a clean pass.
    run_pass(3'd1, 4, 2, ones, 64'd0, 3, 6);
    @(negedge clk);
    check_reset_outputs("post_rst");
    run_pass(3'd4, 3, 2, ones, 64'd0, -1, -1);
    check_eq("clean_fin_cnt", 32'(fin_cyc.size()), 6);

    // Random passes with random valid gaps and FIFO-full pressure.
    for (int k = 0; k < 4; k++) begin
      logic [63:0] av, ff;
      av = {$urandom, $urandom} | {$urandom, $urandom};
      ff = {$urandom, $urandom} & {$urandom, $urandom};
      run_pass(3'($urandom_range(0, 7)), $urandom_range(1, 4), $urandom_range(1, 3), av, ff, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
